// File: rtl/vrf_pkg.sv
// Shared FSM type and elaboration helpers for the VRF read sequencer.
// No logic of its own; consumed via import by the sequencer and its FIFO.
// Backpressure: n/a.
package vrf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } vrf_state_e;

    localparam int VRF_MEM_DEPTH = 512;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // HIGH_PERFORMANCE adds the BRAM output register, costing one extra cycle.
    function automatic int read_latency(input logic [127:0] perf);
        return (perf == 128'("LOW_LATENCY")) ? 1 : 2;
    endfunction

endpackage

// File: rtl/vrf_rd_fifo.sv
// Return-data FIFO, first-word-fall-through, with occupancy count.
// Latency: a push is visible on data/valid the cycle after the write edge.
// Backpressure: caller must never push when full (credit-guaranteed, asserted).
module vrf_rd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [MEM_WIDTH-1:0]               push_data,
    input  logic                               pop,
    output logic [MEM_WIDTH-1:0]               data,
    output logic                               valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [MEM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid  = (count != '0);
    assign data   = mem[rd_ptr];
    assign do_pop = pop && valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            assert (!(push && count == CW'(FIFO_DEPTH)));
        end
    end

endmodule

// File: rtl/vrf_read_sequencer.sv
// Streams a contiguous, wrapping run of VRF words out as a valid/ready stream.
// Latency: start in cycle 0 -> first ren_o cycle 1 -> first valid_o cycle READ_LATENCY+2.
// Backpressure: reads issue only while FIFO occupancy plus in-flight reads leave a free entry.
module vrf_read_sequencer import vrf_pkg::*; #(
    parameter int MEM_DEPTH       = VRF_MEM_DEPTH,
    parameter int MEM_WIDTH       = 32,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [addr_width(MEM_DEPTH)-1:0]     base_addr_i,
    input  logic [len_width(MEM_DEPTH)-1:0]      len_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [addr_width(MEM_DEPTH)-1:0]     raddr_o,
    output logic                                 ren_o,
    output logic                                 oreg_en_o,
    input  logic [MEM_WIDTH-1:0]                 vrf_dout_i,
    output logic [MEM_WIDTH-1:0]                 data_o,
    output logic                                 valid_o,
    output logic                                 last_o,
    input  logic                                 ready_i
);

    localparam int AW = addr_width(MEM_DEPTH);
    localparam int LW = len_width(MEM_DEPTH);
    localparam int RL = read_latency(128'(RAM_PERFORMANCE));
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < RL + 2) begin : g_bad_depth
        $error("vrf_read_sequencer: FIFO_DEPTH must be >= READ_LATENCY+2");
    end

    vrf_state_e     state;
    logic [AW-1:0]  base_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  issue_cnt;
    logic [LW-1:0]  accept_cnt;
    logic [RL-1:0]  lat_sr;
    logic [CW-1:0]  in_flight;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    occupancy;
    logic [AW:0]    addr_sum;
    logic           credit_ok;
    logic           last_read;
    logic           fifo_valid;
    logic           pop;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RL; i++) begin
            in_flight = in_flight + CW'(lat_sr[i]);
        end
    end

    // Registered counts only: a pop this cycle frees its credit next cycle.
    assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
    assign credit_ok = occupancy < (CW + 1)'(FIFO_DEPTH);

    assign ren_o     = (state == ST_ISSUE) && credit_ok;
    assign last_read = ren_o && (issue_cnt == len_q - LW'(1));
    assign oreg_en_o = (RL == 2) ? ~rst : 1'b0;

    // base < MEM_DEPTH and issue_cnt < MEM_DEPTH, so one subtraction wraps.
    assign addr_sum = {1'b0, base_q} + issue_cnt;
    assign raddr_o  = (addr_sum >= (AW + 1)'(MEM_DEPTH))
                      ? AW'(addr_sum - (AW + 1)'(MEM_DEPTH))
                      : AW'(addr_sum);

    assign valid_o = fifo_valid;
    assign last_o  = fifo_valid && (accept_cnt == len_q - LW'(1));
    assign pop     = fifo_valid && ready_i;

    vrf_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_WIDTH  (MEM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lat_sr[RL-1]),
        .push_data (vrf_dout_i),
        .pop       (pop),
        .data      (data_o),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            lat_sr     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            lat_sr <= RL'({lat_sr, ren_o});

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            base_q     <= base_addr_i;
                            len_q      <= len_i;
                            issue_cnt  <= '0;
                            accept_cnt <= '0;
                            busy_o     <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ren_o) begin
                        issue_cnt <= issue_cnt + LW'(1);
                    end
                    if (last_read) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: ;
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                accept_cnt <= accept_cnt + LW'(1);
                if (last_o) begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Directed bench for vrf_read_sequencer with a BRAM model and a beat scoreboard.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_vrf_read_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [8:0]  base_addr_i;
    logic [9:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  raddr_o;
    logic        ren_o;
    logic        oreg_en_o;
    logic [31:0] vrf_dout_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        last_o;
    logic        ready_i;

    logic [31:0] bram_stage;

    int    checks;
    int    failures;
    int    ren_count;
    int    valid_seen;
    int    done_seen;
    int    addr_log [$];
    beat_t exp_q [$];

    // Expected per-cycle {ren, valid, last, done, busy} for base=10 len=4, cycles 1..9.
    logic [4:0] t1_flags [9] = '{5'b10001, 5'b10001, 5'b10001, 5'b11001, 5'b01001,
                                 5'b01001, 5'b01101, 5'b00010, 5'b00000};
    int t1_addr  [4] = '{10, 11, 12, 13};
    int wrap_addr[4] = '{510, 511, 0, 1};

    vrf_read_sequencer #(
        .MEM_DEPTH       (512),
        .MEM_WIDTH       (32),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .raddr_o     (raddr_o),
        .ren_o       (ren_o),
        .oreg_en_o   (oreg_en_o),
        .vrf_dout_i  (vrf_dout_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input int a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    // Two-stage BRAM: array register on ren, output register on oreg_en.
    always_ff @(posedge clk) begin
        if (ren_o) bram_stage <= mem_word(int'(raddr_o));
        if (oreg_en_o) vrf_dout_i <= bram_stage;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int base, input int len);
        beat_t b;
        start_i     = 1'b1;
        base_addr_i = 9'(base);
        len_i       = 10'(len);
        for (int i = 0; i < len; i++) begin
            b.data = mem_word((base + i) % 512);
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done_o && n < max_cycles) begin
            step();
            n++;
        end
        check("done_seen", 64'(done_o), 64'(1));
    endtask

    // Monitor / scoreboard
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ren_o) begin
                    ren_count++;
                    addr_log.push_back(int'(raddr_o));
                end
                if (valid_o) valid_seen++;
                if (done_o) done_seen++;
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none", data_o);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", 64'(data_o), 64'(b.data));
                        check("beat_last", 64'(last_o), 64'(b.last));
                    end
                end
            end
        end
    end

    initial begin
        int r0, v0, d0;
        checks = 0; failures = 0; ren_count = 0; valid_seen = 0; done_seen = 0;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; ready_i = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("reset_outputs", 64'({busy_o, done_o, ren_o, valid_o, last_o}), 64'(0));
        check("reset_raddr", 64'(raddr_o), 64'(0));
        check("oreg_en_hp", 64'(oreg_en_o), 64'(1));

        // base=10 len=4, cycle-exact
        start_req(10, 4);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("t1_flags_c%0d", k),
                  64'({ren_o, valid_o, last_o, done_o, busy_o}), 64'(t1_flags[k-1]));
            if (k <= 4) check($sformatf("t1_raddr_c%0d", k), 64'(raddr_o), 64'(t1_addr[k-1]));
            step();
        end
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // Address wrap
        addr_log.delete();
        start_req(510, 4);
        wait_done(40);
        check("wrap_count", 64'(addr_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check($sformatf("wrap_addr%0d", i), 64'(addr_log[i]), 64'(wrap_addr[i]));
        check("wrap_drained", 64'(exp_q.size()), 64'(0));
        step();

        // Backpressure: ready low for 10 cycles
        ready_i = 1'b0;
        r0 = ren_count;
        start_req(0, 16);
        repeat (9) step();
        check("stall_ren_pulses", 64'(ren_count - r0), 64'(4));
        check("stall_fifo_count", 64'(dut.fifo_count), 64'(4));
        check("stall_valid", 64'(valid_o), 64'(1));
        ready_i = 1'b1;
        wait_done(100);
        check("stall_total_ren", 64'(ren_count - r0), 64'(16));
        check("stall_drained", 64'(exp_q.size()), 64'(0));
        step();

        // len=0
        r0 = ren_count; v0 = valid_seen;
        start_req(5, 0);
        check("len0_c1", 64'({done_o, busy_o, ren_o}), 64'(3'b100));
        repeat (5) step();
        check("len0_no_ren", 64'(ren_count - r0), 64'(0));
        check("len0_no_valid", 64'(valid_seen - v0), 64'(0));

        // start during ISSUE is ignored
        addr_log.delete();
        start_req(100, 6);
        step();
        start_i = 1'b1; base_addr_i = 9'd300; len_i = 10'd3;
        step();
        start_i = 1'b0;
        wait_done(50);
        check("ign_count", 64'(addr_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < addr_log.size(); i++)
            check($sformatf("ign_addr%0d", i), 64'(addr_log[i]), 64'(100 + i));
        check("ign_drained", 64'(exp_q.size()), 64'(0));
        step();

        // Reset mid-request
        start_req(40, 8);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_outputs", 64'({busy_o, done_o, ren_o, valid_o, last_o}), 64'(0));
        check("rst_raddr", 64'(raddr_o), 64'(0));
        rst = 1'b0;
        exp_q.delete();
        v0 = valid_seen; d0 = done_seen;
        repeat (6) step();
        check("rst_no_valid", 64'(valid_seen - v0), 64'(0));
        check("rst_no_done", 64'(done_seen - d0), 64'(0));
        start_req(200, 3);
        wait_done(40);
        check("post_rst_drained", 64'(exp_q.size()), 64'(0));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vrf_read_sequencer.md
Name: vrf_read_sequencer

Overview:
- Drives one VRF read port (raddr/ren/oreg_en) to stream a contiguous run of elements out of the vector register file.
- Returns the elements as a valid/ready stream to a lane consumer (ALU operand path, store unit).
- Tracks the fixed BRAM read latency and absorbs consumer backpressure with a credit-limited FIFO, so no returned word is ever dropped.
- One instance sits beside each VRF read port inside the lane.

Parameters:
- MEM_DEPTH, 512: VRF words per port; addresses wrap modulo MEM_DEPTH.
- MEM_WIDTH, 32: data width in bits.
- RAM_PERFORMANCE, "HIGH_PERFORMANCE": "HIGH_PERFORMANCE" gives READ_LATENCY=2; "LOW_LATENCY" gives READ_LATENCY=1.
- FIFO_DEPTH, 4: return FIFO entries; must be >= READ_LATENCY+2 (elaboration error otherwise).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- base_addr_i  in  $clog2(MEM_DEPTH)  first word address.
- len_i  in  $clog2(MEM_DEPTH)+1  number of words, 0..MEM_DEPTH.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse: request complete.
- raddr_o  out  $clog2(MEM_DEPTH)  VRF read address.
- ren_o  out  1  VRF read enable (one read per asserted cycle).
- oreg_en_o  out  1  VRF output-register enable.
- vrf_dout_i  in  MEM_WIDTH  VRF read data.
- data_o  out  MEM_WIDTH  stream data.
- valid_o  out  1  stream valid.
- last_o  out  1  marks the final word of the request; qualified by valid_o.
- ready_i  in  1  consumer ready.

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Reset values: busy_o=0, done_o=0, ren_o=0, raddr_o=0, valid_o=0, last_o=0. FIFO, counters and latency shift register are cleared. State = IDLE.
- oreg_en_o:
  - HIGH_PERFORMANCE: driven 1 whenever not in reset.
  - LOW_LATENCY: driven 0.
  - The pipeline is never stalled; the FIFO absorbs backpressure.
- State machine: IDLE, ISSUE, DRAIN.
  - IDLE with start_i=1 and len_i>0: latch base and length, issue_cnt=0, accept_cnt=0, go to ISSUE, busy_o=1 next cycle.
  - IDLE with start_i=1 and len_i=0: no reads; done_o pulses the next cycle; busy_o stays 0.
  - ISSUE: ren_o=1 in a cycle iff (fifo_count + in_flight) < FIFO_DEPTH. In that cycle raddr_o = (base + issue_cnt) mod MEM_DEPTH and issue_cnt increments. When the final read is issued, go to DRAIN.
  - DRAIN: ren_o=0. When the beat with last_o=1 is accepted (valid_o & ready_i), pulse done_o next cycle, drop busy_o in that same cycle, return to IDLE.
- start_i is ignored in ISSUE and DRAIN.
- Latency: a READ_LATENCY-deep valid shift register follows ren_o.
  - vrf_dout_i is written into the FIFO on the edge ending the cycle READ_LATENCY cycles after ren_o.
  - The FIFO is first-word-fall-through: valid_o rises the following cycle.
  - Start sampled at cycle 0 gives first ren_o in cycle 1 and first valid_o in cycle READ_LATENCY+2.
- Credits: in_flight = popcount of the shift register. Credit checks use registered counts only; there is no same-cycle pop bypass. With FIFO_DEPTH >= READ_LATENCY+2 and ready_i held high, throughput is one word per cycle.
- Ordering: words emerge in address order. last_o is asserted when accept_cnt == len-1. accept_cnt increments on each handshake.
- The FIFO never overflows: the credit rule guarantees a free entry. Overflow is an assertion failure.
- Wrap: the address increment is modulo MEM_DEPTH. len_i=MEM_DEPTH reads every word exactly once.
- rst asserted mid-request: all state is cleared next edge; in-flight returns are discarded; done_o does not pulse.

Decomposition:
- Package vrf_pkg holds:
  - localparam function for READ_LATENCY from RAM_PERFORMANCE;
  - typedef enum for the FSM states;
  - address/length width constants derived from MEM_DEPTH.
- Sub-module vrf_rd_fifo: synchronous FWFT FIFO with count output, parameters FIFO_DEPTH and MEM_WIDTH.
- The credit logic, latency shift register and FSM stay in the top module.

Test Plan:
- base=10, len=4, ready_i=1, HIGH_PERFORMANCE: raddr_o=10,11,12,13 in cycles 1-4 → valid_o in cycles 4-7 with data in order, last_o in cycle 7, done_o in cycle 8, busy_o low in cycle 8.
- base=510, len=4, MEM_DEPTH=512 → raddr_o sequence 510,511,0,1; data order preserved.
- base=0, len=16, ready_i=0 for 10 cycles then 1 → exactly 4 ren_o pulses before the stall, FIFO holds 4, all 16 words delivered once and in order.
- len=0 start → done_o pulse next cycle, no ren_o, valid_o never high.
- start_i pulsed during ISSUE with different base → ignored; original sequence completes unchanged.
- rst asserted 2 cycles after the first ren_o of a len=8 request → next cycle all outputs at reset values, no valid_o from discarded reads, a new request then runs correctly.
